// File: rtl/exec_arbiter.sv
// Two-requester front end for a shared Execute unit: grant, latch, execute, respond.
// Optional round-robin arbitration is enabled by defining EXEC_ARB_RR_EN.

module Execute #(
    parameter int OP_BIT_WIDTH = 4,
    parameter int DBITS        = 32
) (
    input  logic [OP_BIT_WIDTH-1:0] i_op_alu,
    input  logic [OP_BIT_WIDTH-1:0] i_op_cond,
    input  logic                    i_use_imm,
    input  logic                    i_use_zero,
    input  logic                    i_is_branch,
    input  logic                    i_is_mvhi,
    input  logic [DBITS-1:0]        i_regd,
    input  logic [DBITS-1:0]        i_reg1,
    input  logic [DBITS-1:0]        i_reg2,
    input  logic [DBITS-1:0]        i_imm32,
    input  logic [15:0]             i_immhi,
    output logic [DBITS-1:0]        o_alu,
    output logic                    o_cond
);
    logic [DBITS-1:0] w_b;
    logic [DBITS-1:0] w_cb;
    logic             w_base;

    always_comb begin
        w_b  = i_use_imm ? i_imm32 : i_reg2;
        // Branches compare against the destination register, or zero for the *Z forms.
        w_cb = i_use_zero ? '0 : (i_is_branch ? i_regd : w_b);

        case (i_op_alu)
            4'b0000: o_alu = i_reg1 + w_b;
            4'b0001: o_alu = i_reg1 - w_b;
            4'b0100: o_alu = i_reg1 & w_b;
            4'b0101: o_alu = i_reg1 | w_b;
            4'b0110: o_alu = i_reg1 ^ w_b;
            4'b1100: o_alu = ~(i_reg1 & w_b);
            4'b1101: o_alu = ~(i_reg1 | w_b);
            4'b1110: o_alu = ~(i_reg1 ^ w_b);
            default: o_alu = '0;
        endcase
        if (i_is_mvhi)
            o_alu = {i_immhi, {(DBITS-16){1'b0}}};

        // op_cond[1:0] picks F/EQ/LT/LTE, op_cond[3] inverts (T/NE/GTE/GT).
        case (i_op_cond[1:0])
            2'b01:   w_base = (i_reg1 == w_cb);
            2'b10:   w_base = ($signed(i_reg1) < $signed(w_cb));
            2'b11:   w_base = ($signed(i_reg1) <= $signed(w_cb));
            default: w_base = 1'b0;
        endcase
        o_cond = w_base ^ i_op_cond[3];
    end
endmodule

module exec_arbiter #(
    parameter int                    DBITS        = 32,
    parameter int                    OP_BIT_WIDTH = 4,
    parameter logic [OP_BIT_WIDTH-1:0] OP2_SUB    = 4'b0001
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [1:0]              i_req_valid,
    output logic [1:0]              o_req_ready,
    input  logic [OP_BIT_WIDTH-1:0] i_req0_op1,
    input  logic [OP_BIT_WIDTH-1:0] i_req1_op1,
    input  logic [OP_BIT_WIDTH-1:0] i_req0_op2,
    input  logic [OP_BIT_WIDTH-1:0] i_req1_op2,
    input  logic [DBITS-1:0]        i_req0_regd,
    input  logic [DBITS-1:0]        i_req0_reg1,
    input  logic [DBITS-1:0]        i_req0_reg2,
    input  logic [DBITS-1:0]        i_req1_regd,
    input  logic [DBITS-1:0]        i_req1_reg1,
    input  logic [DBITS-1:0]        i_req1_reg2,
    input  logic [DBITS-1:0]        i_req0_imm32,
    input  logic [DBITS-1:0]        i_req1_imm32,
    input  logic [15:0]             i_req0_immhi,
    input  logic [15:0]             i_req1_immhi,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic                    o_resp_id,
    output logic [DBITS-1:0]        o_resp_alu,
    output logic                    o_resp_cond,
    output logic                    o_busy,
    output logic [1:0]              o_state
);
    // Request: transfer when valid&ready at a clock edge; a losing requester keeps valid high.
    // Response: payload is held until resp_valid&resp_ready at a clock edge.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t                  r_state, w_next;
    logic [1:0]              w_pick;
    logic                    w_xfer, w_gid;
    logic [OP_BIT_WIDTH-1:0] r_op1, r_op2, w_op_alu;
    logic [DBITS-1:0]        r_regd, r_reg1, r_reg2, r_imm32;
    logic [15:0]             r_immhi;
    logic                    r_id;
    logic                    w_is_branch, w_is_sw, w_is_mvhi, w_use_zero, w_use_imm, w_bc;
    logic [DBITS-1:0]        w_alu;
    logic                    w_cond;

`ifdef EXEC_ARB_RR_EN
    logic r_rr_last;
    always_comb begin
        if (&i_req_valid)
            w_pick = r_rr_last ? 2'b01 : 2'b10;
        else
            w_pick = i_req_valid;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_rr_last <= 1'b1;
        else if (w_xfer)
            r_rr_last <= w_gid;
    end
`else
    always_comb begin
        w_pick = i_req_valid[0] ? 2'b01 : {i_req_valid[1], 1'b0};
    end
`endif

    always_comb begin
        o_req_ready = 2'b00;
        w_next      = r_state;
        if (r_state == IDLE)
            o_req_ready = w_pick;
        w_xfer = |(i_req_valid & o_req_ready);
        w_gid  = o_req_ready[1];
        case (r_state)
            IDLE:    if (w_xfer) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (i_resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_is_branch = r_op1[2] & ~r_op1[0];
        w_is_sw     = r_op1[2] & r_op1[0];
        w_is_mvhi   = r_op1[3] & ~r_op1[1] & r_op2[1] & r_op2[0];
        w_use_zero  = (w_is_branch & r_op2[2]) | w_is_mvhi;
        w_use_imm   = r_op1[3] | w_is_sw;
        w_bc        = r_op1[1] & ~r_op1[0];
        w_op_alu    = w_bc ? OP2_SUB : r_op2;
    end

    Execute #(.OP_BIT_WIDTH(OP_BIT_WIDTH), .DBITS(DBITS)) u_execute (
        .i_op_alu   (w_op_alu),
        .i_op_cond  (r_op2),
        .i_use_imm  (w_use_imm),
        .i_use_zero (w_use_zero),
        .i_is_branch(w_is_branch),
        .i_is_mvhi  (w_is_mvhi),
        .i_regd     (r_regd),
        .i_reg1     (r_reg1),
        .i_reg2     (r_reg2),
        .i_imm32    (r_imm32),
        .i_immhi    (r_immhi),
        .o_alu      (w_alu),
        .o_cond     (w_cond)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_op1        <= '0;
            r_op2        <= '0;
            r_regd       <= '0;
            r_reg1       <= '0;
            r_reg2       <= '0;
            r_imm32      <= '0;
            r_immhi      <= '0;
            r_id         <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_alu   <= '0;
            o_resp_cond  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_xfer) begin
                r_id    <= w_gid;
                r_op1   <= w_gid ? i_req1_op1   : i_req0_op1;
                r_op2   <= w_gid ? i_req1_op2   : i_req0_op2;
                r_regd  <= w_gid ? i_req1_regd  : i_req0_regd;
                r_reg1  <= w_gid ? i_req1_reg1  : i_req0_reg1;
                r_reg2  <= w_gid ? i_req1_reg2  : i_req0_reg2;
                r_imm32 <= w_gid ? i_req1_imm32 : i_req0_imm32;
                r_immhi <= w_gid ? i_req1_immhi : i_req0_immhi;
            end
            if (r_state == EXEC) begin
                o_resp_alu   <= w_alu;
                o_resp_cond  <= w_cond;
                o_resp_valid <= 1'b1;
            end
            if (r_state == RESP && i_resp_ready)
                o_resp_valid <= 1'b0;
        end
    end

    assign o_resp_id = r_id;
    assign o_busy    = (r_state != IDLE);
    assign o_state   = r_state;
endmodule
